// File: rtl/bank_read_sequencer.sv
// Round-robin read sequencer for the four-bank byte mux: grants one requester,
// steps the mux selects with a programmable settle time and returns a byte or word.
//
// state | meaning
// IDLE  | accepting requests, selects hold last value
// SEL   | selects driven, hold counter running toward the sample
// RESP  | one-cycle response pulse to the granted requester
module bank_read_sequencer #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [1:0]  req_valid_i,
  input  logic [3:0]  req_addr0_i,
  input  logic [3:0]  req_addr1_i,
  input  logic [1:0]  req_word_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic [1:0]  bank_sel_o,
  output logic [1:0]  byte_sel_o,
  input  logic [7:0]  mux_data_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, SEL, RESP} state_e;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_e      state_q;
  logic        id_q;
  logic        word_q;
  logic        last_grant_q;
  logic [3:0]  cnt_q;
  logic [1:0]  beat_q;
  logic [1:0]  bank_q;
  logic [1:0]  byte_q;
  logic [31:0] data_q;
  logic [1:0]  rsp_valid_q;

  logic [1:0]  grant_d;
  logic        gid_d;
  logic [3:0]  addr_d;
  logic        word_d;

  // Tie goes to the requester that was not served last.
  always_comb begin
    grant_d = 2'b00;
    if (state_q == IDLE && !wb_rst_i) begin
      case (req_valid_i)
        2'b01:   grant_d = 2'b01;
        2'b10:   grant_d = 2'b10;
        2'b11:   grant_d = last_grant_q ? 2'b01 : 2'b10;
        default: grant_d = 2'b00;
      endcase
    end
  end

  assign gid_d  = grant_d[1];
  assign addr_d = gid_d ? req_addr1_i : req_addr0_i;
  assign word_d = req_word_i[gid_d];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      id_q         <= 1'b0;
      word_q       <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      beat_q       <= 2'd0;
      bank_q       <= 2'd0;
      byte_q       <= 2'd0;
      data_q       <= 32'd0;
      rsp_valid_q  <= 2'b00;
    end else begin
      rsp_valid_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (grant_d != 2'b00) begin
            id_q         <= gid_d;
            last_grant_q <= gid_d;
            word_q       <= word_d;
            bank_q       <= addr_d[3:2];
            byte_q       <= word_d ? 2'd0 : addr_d[1:0];
            beat_q       <= 2'd0;
            cnt_q        <= HOLD_LOAD;
            state_q      <= SEL;
          end
        end
        SEL: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (!word_q) begin
            data_q      <= {24'd0, mux_data_i};
            rsp_valid_q <= id_q ? 2'b10 : 2'b01;
            state_q     <= RESP;
          end else begin
            data_q[{beat_q, 3'b000} +: 8] <= mux_data_i;
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              rsp_valid_q <= id_q ? 2'b10 : 2'b01;
              state_q     <= RESP;
            end else begin
              byte_q <= beat_q + 2'd1;
              cnt_q  <= HOLD_LOAD;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = grant_d;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = data_q;
  assign bank_sel_o  = bank_q;
  assign byte_sel_o  = byte_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_bank_read_sequencer.sv
// Bench for bank_read_sequencer: two instances (HOLD_CYCLES 1 and 3) checked every
// cycle against a transaction-timing model, plus directed literal checks.
module tb_bank_read_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        tog = 1'b0;
  logic [1:0]  req_valid [2];
  logic [3:0]  addr0 [2];
  logic [3:0]  addr1 [2];
  logic [1:0]  word [2];
  logic [1:0]  ready [2];
  logic [1:0]  rsp_valid [2];
  logic [31:0] rsp_data [2];
  logic [1:0]  bsel [2];
  logic [1:0]  ysel [2];
  logic [7:0]  mux [2];
  logic        busy [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [4] = '{32'h11223344, 32'hA1B2C3D4, 32'h55667788, 32'hDEADBEEF};
  int          H [2]   = '{1, 3};

  // Mux byte; instance 1 sees every other cycle inverted while tog is set.
  function automatic logic [7:0] muxf(int d, logic [1:0] b, logic [1:0] y, int c);
    logic [31:0] w;
    w = mem[b];
    muxf = w[{y, 3'b000} +: 8] ^ ((tog && d == 1 && c[0]) ? 8'hFF : 8'h00);
  endfunction

  assign mux[0] = muxf(0, bsel[0], ysel[0], cyc);
  assign mux[1] = muxf(1, bsel[1], ysel[1], cyc);

  bank_read_sequencer #(.HOLD_CYCLES(1)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid_i(req_valid[0]),
    .req_addr0_i(addr0[0]), .req_addr1_i(addr1[0]), .req_word_i(word[0]),
    .req_ready_o(ready[0]), .rsp_valid_o(rsp_valid[0]), .rsp_data_o(rsp_data[0]),
    .bank_sel_o(bsel[0]), .byte_sel_o(ysel[0]), .mux_data_i(mux[0]), .busy_o(busy[0]));

  bank_read_sequencer #(.HOLD_CYCLES(3)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .req_valid_i(req_valid[1]),
    .req_addr0_i(addr0[1]), .req_addr1_i(addr1[1]), .req_word_i(word[1]),
    .req_ready_o(ready[1]), .rsp_valid_o(rsp_valid[1]), .rsp_data_o(rsp_data[1]),
    .bank_sel_o(bsel[1]), .byte_sel_o(ysel[1]), .mux_data_i(mux[1]), .busy_o(busy[1]));

  // model: one outstanding transaction per instance, described by its accept cycle
  bit          m_act [2];
  int          m_t [2];
  bit          m_id [2];
  bit          m_word [2];
  bit          m_last [2];
  logic [1:0]  m_bank [2];
  logic [1:0]  m_byte [2];
  logic [1:0]  m_hb [2];
  logic [1:0]  m_hy [2];
  logic [31:0] m_data [2];

  bit          seen_acc [2];
  int          acc_cyc [2];
  logic [1:0]  acc_g [2];
  bit          seen_rsp [2];
  int          rsp_cyc [2];
  logic [1:0]  rsp_v [2];
  logic [31:0] rsp_d [2];

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic mreset(int d);
    m_act[d] = 0; m_last[d] = 1; m_data[d] = 32'd0; m_hb[d] = 2'd0; m_hy[d] = 2'd0;
    m_word[d] = 0; m_t[d] = 0;
  endtask

  task automatic model_cycle();
    for (int d = 0; d < 2; d++) begin
      int len, endc, k, n;
      logic [1:0] e_rdy, e_rv, e_b, e_y;
      logic [3:0] a;
      logic [7:0] v;
      bit e_busy;
      if (rst) mreset(d);
      len  = m_word[d] ? 4 * H[d] : H[d];
      endc = m_t[d] + len + 1;
      if (m_act[d] && cyc > endc) m_act[d] = 0;
      e_busy = m_act[d] && (cyc >= m_t[d] + 1);
      e_b = m_hb[d];
      e_y = m_hy[d];
      if (e_busy) begin
        k   = (cyc - m_t[d] - 1) / H[d];
        e_b = m_bank[d];
        e_y = m_word[d] ? ((k > 3) ? 2'd3 : 2'(k)) : m_byte[d];
      end
      e_rv  = (m_act[d] && cyc == endc) ? (m_id[d] ? 2'b10 : 2'b01) : 2'b00;
      e_rdy = 2'b00;
      if (!rst && !e_busy) begin
        case (req_valid[d])
          2'b01:   e_rdy = 2'b01;
          2'b10:   e_rdy = 2'b10;
          2'b11:   e_rdy = m_last[d] ? 2'b01 : 2'b10;
          default: e_rdy = 2'b00;
        endcase
      end
      chk("ready", {30'd0, ready[d]}, {30'd0, e_rdy});
      chk("rsp_valid", {30'd0, rsp_valid[d]}, {30'd0, e_rv});
      chk("rsp_data", rsp_data[d], m_data[d]);
      chk("bank_sel", {30'd0, bsel[d]}, {30'd0, e_b});
      chk("byte_sel", {30'd0, ysel[d]}, {30'd0, e_y});
      chk("busy", {31'd0, busy[d]}, {31'd0, e_busy});
      if (ready[d] != 2'b00) begin
        seen_acc[d] = 1; acc_cyc[d] = cyc; acc_g[d] = ready[d];
      end
      if (rsp_valid[d] != 2'b00) begin
        seen_rsp[d] = 1; rsp_cyc[d] = cyc; rsp_v[d] = rsp_valid[d]; rsp_d[d] = rsp_data[d];
      end
      m_hb[d] = e_b;
      m_hy[d] = e_y;
      if (e_busy && cyc < endc && ((cyc - m_t[d]) % H[d]) == 0) begin
        n = (cyc - m_t[d]) / H[d] - 1;
        v = muxf(d, m_bank[d], m_word[d] ? 2'(n) : m_byte[d], cyc);
        if (m_word[d]) m_data[d][8*n +: 8] = v;
        else           m_data[d] = {24'd0, v};
      end
      if (e_rdy != 2'b00) begin
        a         = e_rdy[1] ? addr1[d] : addr0[d];
        m_act[d]  = 1;
        m_t[d]    = cyc;
        m_id[d]   = e_rdy[1];
        m_last[d] = e_rdy[1];
        m_word[d] = word[d][e_rdy[1]];
        m_bank[d] = a[3:2];
        m_byte[d] = m_word[d] ? 2'd0 : a[1:0];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(int d);
    for (int i = 0; i < 80 && !seen_acc[d]; i++) step();
    chk("acc_seen", {31'd0, seen_acc[d]}, 32'd1);
  endtask

  task automatic wait_rsp(int d);
    for (int i = 0; i < 80 && !seen_rsp[d]; i++) step();
    chk("rsp_seen", {31'd0, seen_rsp[d]}, 32'd1);
  endtask

  int t0;

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 2'b00; addr0[d] = 4'd0; addr1[d] = 4'd0; word[d] = 2'b00;
      seen_acc[d] = 0; seen_rsp[d] = 0;
      mreset(d);
    end
    #1 rst = 1'b1;
    req_valid[0] = 2'b11; addr0[0] = 4'b0110; addr1[0] = 4'b1100; word[0] = 2'b10;
    repeat (3) step();
    chk("rst_ready", {30'd0, ready[0]}, 32'd0);
    chk("rst_data", rsp_data[0], 32'd0);
    rst = 1'b0;

    // tie after reset goes to requester 0 (byte), then requester 1 (word)
    wait_acc(0);
    chk("first_grant", {30'd0, acc_g[0]}, 32'h1);
    t0 = acc_cyc[0];
    req_valid[0] = 2'b10;
    wait_rsp(0);
    chk("byte_lat", rsp_cyc[0] - t0, 32'd2);
    chk("byte_vld", {30'd0, rsp_v[0]}, 32'h1);
    chk("byte_data", rsp_d[0], 32'h000000B2);
    seen_acc[0] = 0;
    wait_acc(0);
    chk("word_grant", {30'd0, acc_g[0]}, 32'h2);
    t0 = acc_cyc[0];
    req_valid[0] = 2'b00;
    seen_rsp[0] = 0;
    wait_rsp(0);
    chk("word_lat", rsp_cyc[0] - t0, 32'd5);
    chk("word_vld", {30'd0, rsp_v[0]}, 32'h2);
    chk("word_data", rsp_d[0], 32'hDEADBEEF);

    // both continuously valid: grants alternate 0,1,0,1
    addr0[0] = 4'b0001; addr1[0] = 4'b1011; word[0] = 2'b00; req_valid[0] = 2'b11;
    for (int g = 0; g < 4; g++) begin
      seen_acc[0] = 0;
      wait_acc(0);
      chk("alt_grant", {30'd0, acc_g[0]}, (g % 2) ? 32'h2 : 32'h1);
    end
    req_valid[0] = 2'b00;
    seen_rsp[0] = 0;
    wait_rsp(0);
    chk("alt_last_vld", {30'd0, rsp_v[0]}, 32'h2);
    chk("alt_last_data", rsp_d[0], 32'h00000055);

    // reset during beat 2 of a word read
    addr0[0] = 4'b1100; word[0] = 2'b01; req_valid[0] = 2'b01;
    seen_acc[0] = 0;
    wait_acc(0);
    req_valid[0] = 2'b00;
    step();
    step();
    chk("mid_beat2_sel", {30'd0, ysel[0]}, 32'd2);
    rst = 1'b1;
    seen_rsp[0] = 0;
    step();
    chk("mid_rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("mid_rst_data", rsp_data[0], 32'd0);
    rst = 1'b0;
    repeat (8) step();
    chk("no_rsp_after_rst", {31'd0, seen_rsp[0]}, 32'd0);
    addr0[0] = 4'b0110; word[0] = 2'b00; req_valid[0] = 2'b01;
    seen_acc[0] = 0;
    wait_acc(0);
    t0 = acc_cyc[0];
    req_valid[0] = 2'b00;
    wait_rsp(0);
    chk("post_rst_lat", rsp_cyc[0] - t0, 32'd2);
    chk("post_rst_data", rsp_d[0], 32'h000000B2);

    // HOLD_CYCLES=3 with a toggling mux output
    tog = 1'b1;
    addr0[1] = 4'b0110; word[1] = 2'b00; req_valid[1] = 2'b01;
    wait_acc(1);
    t0 = acc_cyc[1];
    req_valid[1] = 2'b00;
    wait_rsp(1);
    chk("h3_lat", rsp_cyc[1] - t0, 32'd4);
    chk("h3_data", rsp_d[1], {24'd0, 8'hB2 ^ (((t0 + 3) % 2 != 0) ? 8'hFF : 8'h00)});
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bank_read_sequencer.md
# bank_read_sequencer

Read controller in front of the four-bank byte read mux. It arbitrates byte and word read requests from two requesters with round-robin priority, and drives the mux bank/byte selects. For a word read it steps the byte select through all four bytes, holding each select for a programmable settle time before sampling the mux output. It then returns the byte or assembled 32-bit word to the requester that was granted.

## Interface
Parameters:
- HOLD_CYCLES, 1: cycles each select is held before the mux output is sampled; legal range 1..15; 0 is illegal.

Ports:
- wb_clk_i  in  1  single clock; all state changes on its rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  2  request valid per requester; bit0 = requester 0, bit1 = requester 1.
- req_addr0_i  in  4  requester 0 address {bank[3:2], byte[1:0]}.
- req_addr1_i  in  4  requester 1 address, same format.
- req_word_i  in  2  per requester; 1 = word read of the addressed bank, addr[1:0] ignored.
- req_ready_o  out  2  one-hot grant; a request is accepted when valid and ready are both high in the same cycle.
- rsp_valid_o  out  2  one-cycle response pulse to the granted requester.
- rsp_data_o  out  32  response data. A byte read returns the byte in [7:0] with [31:8] = 0. A word read returns byte n in [8n+7:8n].
- bank_sel_o  out  2  drives the mux bank select.
- byte_sel_o  out  2  drives the mux byte select.
- mux_data_i  in  8  mux byte output; combinational from the selects.
- busy_o  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: accepts requests; req_ready_o nonzero only here.
  - SEL: select driven; hold counter runs.
  - RESP: one cycle; pulses rsp_valid_o.
- Arbitration (IDLE):
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted last time wins.
  - last_grant resets to 1, so requester 0 wins the first tie after reset.
  - req_ready_o is combinational from req_valid_i and last_grant while in IDLE, and 0 in every other state.
- On accept:
  - Latch requester id, bank, start byte (0 for a word read) and word flag.
  - Update last_grant.
  - Go to SEL.
- SEL:
  - bank_sel_o and byte_sel_o are registered, updated on the accept edge or beat edge.
  - The hold counter loads HOLD_CYCLES-1 on entry and counts down.
  - At count 0, mux_data_i is sampled: byte read into rsp_data_o[7:0]; word read into the byte lane of the current beat.
- Byte read: after the sample, go to RESP.
- Word read:
  - The 2-bit beat counter increments and byte_sel_o follows it; the counter reloads and the machine stays in SEL.
  - After the beat-3 sample, go to RESP.
  - The beat counter wraps 3->0.
- RESP: rsp_valid_o[id] = 1 for exactly one cycle, then IDLE.
- rsp_data_o:
  - Holds its value after the pulse until the next sample overwrites it.
  - A byte read clears [31:8] on its sample.
  - A word read overwrites all four lanes.
- Selects hold their last value in IDLE.
- Requesters hold valid, address and word flag stable until ready. A valid dropped before ready is legal and produces no grant.
- Reset asserted at any time, including mid-burst:
  - All state goes to IDLE immediately.
  - The outstanding request is discarded, with no rsp_valid_o.
- Reset values: req_ready_o = 0 while reset is asserted; rsp_valid_o = 0; rsp_data_o = 0; bank_sel_o = 0; byte_sel_o = 0; busy_o = 0; last_grant = 1.

## Timing
- Accept at cycle T; selects valid from T+1.
- Byte read:
  - Sample at the end of cycle T+HOLD_CYCLES.
  - rsp_valid_o at T+HOLD_CYCLES+1.
- Word read:
  - Beat n selects valid from T+1+n*HOLD_CYCLES.
  - rsp_valid_o at T+4*HOLD_CYCLES+1.
- Next accept no earlier than the cycle after RESP. Byte throughput is one per HOLD_CYCLES+2 cycles.
- mux_data_i is ignored in every cycle except the sample cycles.

## Test plan
- Reset: hold wb_rst_i high with both requests valid -> all outputs 0 and no ready. Release reset -> req_ready_o = 01.
- Byte read, HOLD_CYCLES=1, bank1 = 0xA1B2C3D4. Requester 0 addr 4'b0110 accepted at T -> bank_sel_o = 1 and byte_sel_o = 2 at T+1; rsp_valid_o = 01 at T+2; rsp_data_o = 0x000000B2.
- Word read, HOLD_CYCLES=1, bank3 = 0xDEADBEEF, requester 1 -> byte_sel_o = 0,1,2,3 on cycles T+1..T+4; rsp_valid_o = 10 at T+5; rsp_data_o = 0xDEADBEEF.
- Both requesters continuously valid with byte reads -> grants 0,1,0,1. Each rsp_valid_o goes to the matching requester with its own byte.
- Reset asserted for 1 cycle during word-read beat 2 -> outputs 0 at once, no rsp_valid_o. A following byte read completes at T+2.
- HOLD_CYCLES=3, mux_data_i toggled every cycle -> rsp_data_o equals the value present at T+3, and rsp_valid_o fires at T+4.
